// File: rtl/cpu_defs_pkg.sv
// Shared CPU pipeline definitions: datapath width, ALU op codes, operand source
// encodings and the EX-stage control bundle.
package cpu_defs_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_LUI  = 5'd10,
    ALU_BEQ  = 5'd11,
    ALU_BNE  = 5'd12,
    ALU_BLT  = 5'd13,
    ALU_BGE  = 5'd14,
    ALU_BLTU = 5'd15,
    ALU_BGEU = 5'd16,
    ALU_JAL  = 5'd17,
    ALU_JALR = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_e;

  // Source selects stay raw 2-bit fields so the unused 2'b11 code survives capture.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:     1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    rd:        5'd0,
    rs1:       5'd0,
    rs2:       5'd0,
    alu_op:    ALU_ADD,
    src_a:     SRC_A_RS1,
    src_b:     SRC_B_RS2
  };

endpackage

// File: rtl/operand_fwd_mux.sv
// Selects the freshest value of one source register: MEM result, then WB result,
// then the value captured in the ID/EX register. x0 is never forwarded.
module operand_fwd_mux
  import cpu_defs_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned FWD_EN = 1
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = (FWD_EN != 0) && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs);
  assign wb_hit  = (FWD_EN != 0) && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs);

  always_comb begin
    fwd_data = reg_data;
    if (mem_hit) begin
      fwd_data = mem_result;
    end else if (wb_hit) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall control
// and MEM/WB operand forwarding into the ALU operand selects.
module id_ex_stage
  import cpu_defs_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned FWD_EN = 1
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_alu_op,
  input  logic [1:0]      id_src_a,
  input  logic [1:0]      id_src_b,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_op,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_stall
);

  ex_ctrl_t        ctrl_q;
  ex_ctrl_t        ctrl_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs1_data_d;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] rs2_data_d;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load in EX whose destination is read by the instruction in ID.
  assign load_use_stall = ctrl_q.valid & ctrl_q.mem_read & (ctrl_q.rd != 5'd0) & id_valid &
                          ((id_rs1 == ctrl_q.rd) | (id_rs2 == ctrl_q.rd));

  // Next-state select: flush > load-use bubble > stall (hold) > capture.
  always_comb begin
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    if (flush || load_use_stall) begin
      ctrl_d     = BUBBLE_CTRL;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
    end else if (!stall) begin
      ctrl_d.valid     = id_valid;
      ctrl_d.reg_write = id_reg_write;
      ctrl_d.mem_read  = id_mem_read;
      ctrl_d.mem_write = id_mem_write;
      ctrl_d.rd        = id_rd;
      ctrl_d.rs1       = id_rs1;
      ctrl_d.rs2       = id_rs2;
      ctrl_d.alu_op    = id_alu_op;
      ctrl_d.src_a     = id_src_a;
      ctrl_d.src_b     = id_src_b;
      pc_d             = id_pc;
      rs1_data_d       = id_rs1_data;
      rs2_data_d       = id_rs2_data;
      imm_d            = id_imm;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ctrl_q     <= BUBBLE_CTRL;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  operand_fwd_mux #(
    .XLEN   (XLEN),
    .FWD_EN (FWD_EN)
  ) u_fwd_rs1 (
    .rs            (ctrl_q.rs1),
    .reg_data      (rs1_data_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs1)
  );

  operand_fwd_mux #(
    .XLEN   (XLEN),
    .FWD_EN (FWD_EN)
  ) u_fwd_rs2 (
    .rs            (ctrl_q.rs2),
    .reg_data      (rs2_data_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs2)
  );

  always_comb begin
    alu_a = '0;
    if (ctrl_q.valid) begin
      case (ctrl_q.src_a)
        SRC_A_RS1: alu_a = fwd_rs1;
        SRC_A_PC:  alu_a = pc_q;
        default:   alu_a = '0;
      endcase
    end
  end

  always_comb begin
    alu_b = '0;
    if (ctrl_q.valid) begin
      case (ctrl_q.src_b)
        SRC_B_RS2:  alu_b = fwd_rs2;
        SRC_B_IMM:  alu_b = imm_q;
        SRC_B_FOUR: alu_b = XLEN'(3'd4);
        default:    alu_b = '0;
      endcase
    end
  end

  assign alu_op        = ctrl_q.valid ? ctrl_q.alu_op : ALU_ADD;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_rd         = ctrl_q.rd;
  assign ex_pc         = pc_q;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes expected EX outputs from a
// behavioural model, a negedge monitor pops and compares them.
module tb_id_ex_stage;
  import cpu_defs_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op;
  logic [1:0]  id_src_a, id_src_b;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [4:0]  alu_op, ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  id_ex_stage #(.XLEN(32), .FWD_EN(1)) dut (
    .CLK(CLK), .RSTn(RSTn), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        valid, rw, mr, mw;
    bit [4:0]  rs1, rs2, rd, op;
    bit [1:0]  sa, sb;
    bit [31:0] pc, d1, d2, imm;
  } instr_t;

  typedef struct {
    bit        valid, rw, mr, mw, lus;
    bit [4:0]  rd, op;
    bit [31:0] pc, store, a, b;
  } exp_t;

  instr_t m;
  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit [31:0] fwd(bit [4:0] rs, bit [31:0] regval);
    if (rs != 0 && mem_reg_write && mem_rd == rs) return mem_result;
    if (rs != 0 && wb_reg_write && wb_rd == rs) return wb_result;
    return regval;
  endfunction

  function automatic bit hazard();
    return m.valid && m.mr && m.rd != 0 && id_valid && (id_rs1 == m.rd || id_rs2 == m.rd);
  endfunction

  // Advance the model across one rising edge using the inputs that were stable before it.
  task automatic tick();
    bit lus;
    @(posedge CLK);
    #1;
    lus = hazard();
    if (!RSTn || flush || lus) begin
      m = '{default: '0};
    end else if (!stall) begin
      m.valid = id_valid;   m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
      m.rs1 = id_rs1;       m.rs2 = id_rs2;      m.rd = id_rd;       m.op = id_alu_op;
      m.sa = id_src_a;      m.sb = id_src_b;     m.pc = id_pc;
      m.d1 = id_rs1_data;   m.d2 = id_rs2_data;  m.imm = id_imm;
    end
  endtask

  task automatic push();
    exp_t e;
    bit [31:0] f1, f2;
    if (!RSTn) m = '{default: '0};
    f1 = fwd(m.rs1, m.d1);
    f2 = fwd(m.rs2, m.d2);
    e.valid = m.valid; e.rw = m.rw; e.mr = m.mr; e.mw = m.mw;
    e.rd = m.rd; e.pc = m.pc; e.store = f2; e.lus = hazard();
    e.op = m.valid ? m.op : 5'd0;
    e.a = !m.valid ? 32'd0 : (m.sa == 2'd0) ? f1 : (m.sa == 2'd1) ? m.pc : 32'd0;
    e.b = !m.valid ? 32'd0 : (m.sb == 2'd0) ? f2 : (m.sb == 2'd1) ? m.imm :
          (m.sb == 2'd2) ? 32'd4 : 32'd0;
    q.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_valid", ex_valid, e.valid);
      chk("ex_reg_write", ex_reg_write, e.rw);
      chk("ex_mem_read", ex_mem_read, e.mr);
      chk("ex_mem_write", ex_mem_write, e.mw);
      chk("ex_rd", ex_rd, e.rd);
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_store_data", ex_store_data, e.store);
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      chk("alu_op", alu_op, e.op);
      chk("load_use_stall", load_use_stall, e.lus);
    end
  end

  task automatic set_id(bit v, bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd, bit [4:0] op,
                        bit [1:0] sa, bit [1:0] sb, bit rw, bit mr, bit mw,
                        bit [31:0] pc, bit [31:0] d1, bit [31:0] d2, bit [31:0] imm);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_op = op;
    id_src_a = sa; id_src_b = sb; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
  endtask

  task automatic quiet();
    stall = 0; flush = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  initial begin
    m = '{default: '0};
    RSTn = 0;
    quiet();
    set_id(1, 1, 2, 3, 5'd1, 2'd0, 2'd1, 1, 0, 0, 32'h10, 32'h11, 32'h22, 32'h33);

    // Reset held with a valid instruction presented
    tick(); push(); #1;
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_alu_op", alu_op, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    tick(); RSTn = 1; push();

    // MEM beats WB; forwarding re-evaluated while stalled
    tick();
    set_id(1, 5, 6, 9, 5'd0, 2'd0, 2'd1, 1, 0, 0, 32'h20, 32'hAAAA, 32'hBBBB, 32'h10); push();
    tick();
    stall = 1;
    mem_reg_write = 1; mem_rd = 5; mem_result = 32'h1234;
    wb_reg_write = 1;  wb_rd = 5;  wb_result = 32'hBEEF;
    push(); #1; chk("mem_fwd_alu_a", alu_a, 32'h1234);
    tick(); mem_rd = 6; push(); #1; chk("stall_wb_fwd_alu_a", alu_a, 32'hBEEF);
    tick(); wb_rd = 3;  push(); #1; chk("stall_no_fwd_alu_a", alu_a, 32'hAAAA);

    // x0 is never forwarded
    tick(); quiet();
    set_id(1, 0, 0, 4, 5'd0, 2'd2, 2'd0, 1, 0, 0, 32'h30, 32'h0, 32'h0, 32'h0); push();
    tick(); stall = 1; mem_reg_write = 1; mem_rd = 0; mem_result = 32'hFFFF_FFFF; push(); #1;
    chk("x0_alu_b", alu_b, 0);
    chk("x0_store_data", ex_store_data, 0);

    // Load-use hazard
    tick(); quiet();
    set_id(1, 1, 2, 7, 5'd0, 2'd0, 2'd1, 1, 1, 0, 32'h34, 32'h1, 32'h2, 32'h4); push();
    tick();
    set_id(1, 1, 7, 8, 5'd1, 2'd0, 2'd0, 1, 0, 0, 32'h38, 32'h5, 32'h6, 32'h0); push(); #1;
    chk("load_use_flag", load_use_stall, 1);
    tick(); push(); #1;
    chk("load_use_ex_valid", ex_valid, 0);
    chk("load_use_ex_reg_write", ex_reg_write, 0);

    // Flush beats stall; stall holds for three cycles
    tick();
    set_id(1, 3, 4, 5, 5'd2, 2'd0, 2'd0, 1, 0, 0, 32'h40, 32'h7, 32'h8, 32'h0); push();
    tick(); flush = 1; stall = 1; push();
    tick(); flush = 0; stall = 0; push(); #1; chk("flush_over_stall", ex_valid, 0);
    tick();
    stall = 1;
    set_id(1, 3, 4, 5, 5'd2, 2'd0, 2'd0, 1, 0, 0, 32'h80, 32'h7, 32'h8, 32'h0); push();
    for (int i = 0; i < 3; i++) begin
      tick(); push(); #1; chk("stall_hold_pc", ex_pc, 32'h40);
    end

    // PC + 4 operand path
    tick(); stall = 0;
    set_id(1, 1, 2, 10, 5'd0, 2'd1, 2'd2, 1, 0, 0, 32'h100, 32'h9, 32'h9, 32'h0); push();
    tick(); push(); #1;
    chk("pc_path_alu_a", alu_a, 32'h100);
    chk("pc_path_alu_b", alu_b, 32'd4);

    // Reset overrides flush and stall; first capture after release
    tick(); RSTn = 0; stall = 1; flush = 1; push(); #1;
    chk("reset_mid_flush_valid", ex_valid, 0);
    chk("reset_mid_flush_pc", ex_pc, 0);
    tick(); RSTn = 1; quiet();
    set_id(1, 1, 2, 11, 5'd3, 2'd1, 2'd1, 1, 0, 0, 32'h200, 32'h1, 32'h2, 32'h3); push();
    tick(); push(); #1; chk("first_capture_pc", ex_pc, 32'h200);

    // Randomized traffic with small register indices to provoke hazards and forwarding
    for (int n = 0; n < 600; n++) begin
      tick();
      RSTn          = ($urandom_range(0, 99) != 0);
      flush         = ($urandom_range(0, 9) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      mem_reg_write = $urandom_range(0, 1);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_result    = $urandom;
      wb_reg_write  = $urandom_range(0, 1);
      wb_rd         = 5'($urandom_range(0, 3));
      wb_result     = $urandom;
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom, $urandom);
      push();
    end

    tick(); RSTn = 1; quiet();
    @(negedge CLK);
    #1;
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
